// File: rtl/pulse_counter.sv
// rtl/pulse_counter.sv - push-button one-pulser driving a LOW_BOUND..15 wrap counter with load and carry.
// Optional debounce stage enabled by defining PULSE_COUNTER_DEBOUNCE_EN.
module pulse_counter #(
  parameter logic [3:0] LOW_BOUND  = 4'd5,
  parameter int         DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkPB,
  input  logic       ld,
  input  logic [3:0] par_in,
  output logic [3:0] Count_out,
  output logic       Co
);

  typedef enum logic [1:0] {
    WAIT_PRESS,
    PULSE,
    WAIT_RELEASE
  } state_t;

  if (DEB_CYCLES < 2) begin : g_deb_cycles_chk
    $error("pulse_counter: DEB_CYCLES must be >= 2");
  end

  logic       r_sync1;
  logic       r_sync2;
  logic       w_btn;
  state_t     r_state;
  logic       w_cnt_en;
  logic [3:0] w_ld_val;
  logic [3:0] r_count;
  logic       r_co;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= clkPB;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PULSE_COUNTER_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES) + 1;

  logic [DW-1:0] r_deb_cnt;
  logic          r_deb_prev;
  logic          r_deb_out;

  // Output follows the input once the count of matching samples fills the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_cnt  <= '0;
      r_deb_prev <= 1'b0;
      r_deb_out  <= 1'b0;
    end else begin
      r_deb_prev <= r_sync2;
      if (r_sync2 != r_deb_prev) begin
        r_deb_cnt <= '0;
      end else begin
        if (r_deb_cnt != DW'(DEB_CYCLES - 1)) begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
        if (r_deb_cnt >= DW'(DEB_CYCLES - 2)) begin
          r_deb_out <= r_sync2;
        end
      end
    end
  end

  assign w_btn = r_deb_out;
`else
  assign w_btn = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_PRESS;
    end else begin
      case (r_state)
        WAIT_PRESS:   if (w_btn) r_state <= PULSE;
        PULSE:        r_state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!w_btn) r_state <= WAIT_PRESS;
        default:      r_state <= WAIT_PRESS;
      endcase
    end
  end

  assign w_cnt_en = (r_state == PULSE);
  assign w_ld_val = (par_in < LOW_BOUND) ? LOW_BOUND : par_in;

  // Load wins over the enable; a coincident pulse is dropped, not held over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= LOW_BOUND;
      r_co    <= 1'b0;
    end else if (ld) begin
      r_count <= w_ld_val;
      r_co    <= 1'b0;
    end else if (w_cnt_en) begin
      if (r_count == 4'd15) begin
        r_count <= LOW_BOUND;
        r_co    <= 1'b1;
      end else begin
        r_count <= r_count + 4'd1;
        r_co    <= 1'b0;
      end
    end else begin
      r_co <= 1'b0;
    end
  end

  assign Count_out = r_count;
  assign Co        = r_co;

endmodule

// File: tb/tb_pulse_counter.sv
// tb/tb_pulse_counter.sv - directed checks for pulse_counter with debounce disabled.
module tb_pulse_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clkPB;
  logic       ld;
  logic [3:0] par_in;
  logic [3:0] Count_out;
  logic       Co;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_counter #(.LOW_BOUND(4'd5), .DEB_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clkPB     (clkPB),
    .ld        (ld),
    .par_in    (par_in),
    .Count_out (Count_out),
    .Co        (Co)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] par_in;
    logic [3:0] exp_count;
    logic       exp_co;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Press for `hold` cycles, release for 5; reports how many cycles Co was high.
  task automatic press(input int hold, output int co_cycles);
    co_cycles = 0;
    clkPB = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (Co) co_cycles++;
    end
    clkPB = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Co) co_cycles++;
    end
  endtask

  initial begin
    int co_cnt;

    rst = 1'b0; clkPB = 1'b0; ld = 1'b0; par_in = 4'd0;

    vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'd5,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,  4'd5,  1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd12, 4'd12, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd0,  4'd5,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd4,  4'd5,  1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'd6,  4'd6,  1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd12, 4'd5,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd9,  4'd5,  1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd5,  4'd5,  1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd2,  4'd15, 1'b0};

    // Reset state, then a 20-cycle hold yields a single increment at edge N+3.
    do_reset();
    check("reset_count", Count_out, 5);
    check("reset_co", Co, 0);
    clkPB = 1'b1;
    tick(); tick(); tick();
    check("latency_before_n3", Count_out, 5);
    tick();
    check("latency_at_n3", Count_out, 6);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("hold_no_repeat", Count_out, 6);
      check("hold_co_low", Co, 0);
    end
    clkPB = 1'b0;
    repeat (5) tick();

    // Eleven presses from reset walk 6..15 then wrap to 5 with one Co cycle.
    do_reset();
    for (int p = 1; p <= 11; p++) begin
      press(5, co_cnt);
      check("press_count", Count_out, (p == 11) ? 5 : 5 + p);
      check("press_co_cycles", co_cnt, (p == 11) ? 1 : 0);
    end

    // Load/reset vector table.
    for (int i = 0; i < 11; i++) begin
      rst    = vecs[i].rst;
      ld     = vecs[i].ld;
      par_in = vecs[i].par_in;
      tick();
      rst = 1'b0;
      ld  = 1'b0;
      check($sformatf("vec%0d_count", i), Count_out, vecs[i].exp_count);
      check($sformatf("vec%0d_co", i), Co, vecs[i].exp_co);
    end

    // From a loaded 15, one press wraps.
    press(5, co_cnt);
    check("load15_wrap_count", Count_out, 5);
    check("load15_wrap_co", co_cnt, 1);

    // Load coincident with the PULSE-state enable: enable is discarded.
    do_reset();
    clkPB = 1'b1;
    tick(); tick(); tick();
    ld = 1'b1; par_in = 4'd9;
    tick();
    ld = 1'b0;
    check("ld_vs_pulse", Count_out, 9);
    repeat (6) tick();
    check("ld_vs_pulse_no_defer", Count_out, 9);
    clkPB = 1'b0;
    repeat (5) tick();
    check("ld_vs_pulse_after_release", Count_out, 9);

    // Reset during WAIT_RELEASE with button held: one fresh pulse afterwards.
    do_reset();
    clkPB = 1'b1;
    repeat (4) tick();
    check("pre_rst_count", Count_out, 6);
    repeat (2) tick();
    do_reset();
    check("mid_press_rst_count", Count_out, 5);
    check("mid_press_rst_co", Co, 0);
    tick(); tick(); tick();
    check("post_rst_wait", Count_out, 5);
    tick();
    check("post_rst_pulse", Count_out, 6);
    repeat (10) tick();
    check("post_rst_single", Count_out, 6);
    clkPB = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_counter.md
PULSE_COUNTER -- requirements
Module: pulse_counter

Interface
REQ-001 Parameter: LOW_BOUND, 5, lowest count value and wrap target (4-bit, 0..15).
REQ-002 Parameter: DEB_CYCLES, 16, debounce stability window in clk cycles (used only under DEBOUNCE_EN, >=2).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: clkPB  input  1  raw asynchronous push-button; each press advances the count once.
REQ-006 Port: ld  input  1  synchronous parallel-load request.
REQ-007 Port: par_in  input  4  load value.
REQ-008 Port: Count_out  output  4  registered count; drives the downstream two-digit SSD decoder.
REQ-009 Port: Co  output  1  registered carry; one-cycle pulse on wrap 15 -> LOW_BOUND.

Function
REQ-010 clkPB SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 A one-pulser FSM SHALL have states WAIT_PRESS, PULSE, WAIT_RELEASE.
REQ-012 WAIT_PRESS -> PULSE when conditioned button = 1; otherwise stay.
REQ-013 PULSE -> WAIT_RELEASE unconditionally; internal count enable = 1 only in PULSE (exactly one cycle per press).
REQ-014 WAIT_RELEASE -> WAIT_PRESS when conditioned button = 0; otherwise stay (held button yields no further pulses).
REQ-015 Without DEBOUNCE_EN, clkPB first sampled high at edge N SHALL change Count_out at edge N+3.
REQ-016 Count enable with Count_out < 15: Count_out <= Count_out + 1, Co <= 0.
REQ-017 Count enable with Count_out = 15: Count_out <= LOW_BOUND, Co <= 1 for exactly that one cycle.
REQ-018 Co SHALL be 0 in every cycle not following a wrap.
REQ-019 ld = 1: Count_out <= max(par_in, LOW_BOUND) (values below LOW_BOUND clamp to LOW_BOUND), Co <= 0.
REQ-020 Priority: rst > ld > count enable; an enable coincident with ld SHALL be discarded, not deferred.
REQ-021 ld SHALL NOT alter FSM state; a press in progress completes normally.
REQ-022 Count_out SHALL always lie in LOW_BOUND..15.

Reset
REQ-023 rst = 1 at a rising edge: Count_out <= LOW_BOUND (5), Co <= 0, FSM <= WAIT_PRESS, synchronizer and debounce registers <= 0.
REQ-024 rst asserted mid-press: FSM returns to WAIT_PRESS; a button still held after rst release SHALL generate one new pulse.
REQ-025 rst SHALL override ld and count enable in the same cycle.

Configuration
REQ-026 Macro PULSE_COUNTER_DEBOUNCE_EN defined: synchronized button feeds the FSM only after DEB_CYCLES consecutive identical samples; any toggle restarts the window; latency becomes N+3+DEB_CYCLES.
REQ-027 Macro undefined: no debounce logic; synchronizer output feeds the FSM directly (REQ-015 latency).

Verification
REQ-028 rst 1 cycle -> Count_out = 5, Co = 0; hold clkPB high 20 cycles (macro off) -> Count_out = 6 exactly once, no further change.
REQ-029 11 separate presses from reset -> Count_out 6..15, then 5 with Co = 1 for one cycle only.
REQ-030 ld = 1, par_in = 3 -> Count_out = 5; ld = 1, par_in = 12 -> Count_out = 12.
REQ-031 ld asserted in the same cycle as the PULSE-state enable, par_in = 9 -> Count_out = 9, not 10.
REQ-032 rst during WAIT_RELEASE with clkPB held -> Count_out = 5, then 6 after rst release (one pulse).
REQ-033 Macro on, DEB_CYCLES = 16: 5-cycle glitch on clkPB -> no count; 20-cycle press -> exactly one increment.
